// File: rtl/reg_file_sb_pkg.sv
// Shared defaults, derived-width helpers and busy-vector type for the
// scoreboarded register file.
package reg_file_pkg;

  localparam int DEF_XLEN = 8;
  localparam int DEF_NREG = 32;
  localparam int DEF_NRD  = 2;

  function automatic int aw_of(int nreg);
    return (nreg <= 2) ? 1 : $clog2(nreg);
  endfunction

  function automatic int cw_of(int nreg);
    return $clog2(nreg + 1);
  endfunction

  typedef logic [DEF_NREG-1:0] busy_vec_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback side bus of the register file: read ports, writeback,
// reserve, flush and the registered busy count.
interface reg_file_sb_if #(
  parameter int XLEN = reg_file_pkg::DEF_XLEN,
  parameter int NREG = reg_file_pkg::DEF_NREG,
  parameter int NRD  = reg_file_pkg::DEF_NRD
) ();
  localparam int AW = reg_file_pkg::aw_of(NREG);
  localparam int CW = reg_file_pkg::cw_of(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                flush;
  logic [CW-1:0]       busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, busy_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// Multi-port register file with write-to-read bypass, optional hardwired zero
// register and a per-register busy scoreboard with a registered busy count.
module reg_file_sb import reg_file_pkg::*; #(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREG     = DEF_NREG,
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_sb_if.slave  bus
);
  localparam int AW = aw_of(NREG);
  localparam int CW = cw_of(NREG);

  logic [XLEN-1:0]     r_mem [NREG];
  logic [NREG-1:0]     r_busy;
  logic [CW-1:0]       r_busy_cnt;

  logic                w_wr_ok;
  logic                w_rsv_ok;
  logic                w_inc;
  logic                w_dec;
  logic [NREG-1:0]     w_busy_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [NRD*XLEN-1:0] w_rd_data;
  logic [NRD-1:0]      w_rd_busy;

  assign w_wr_ok  = bus.wr_en && (int'(bus.wr_addr) < NREG) &&
                    !((ZERO_REG != 0) && (bus.wr_addr == '0));
  // flush squashes any reservation arriving in the same cycle
  assign w_rsv_ok = bus.rsv_en && !bus.flush && (int'(bus.rsv_addr) < NREG) &&
                    !((ZERO_REG != 0) && (bus.rsv_addr == '0));

  always_comb begin
    w_busy_nxt = r_busy;
    w_inc      = 1'b0;
    w_dec      = 1'b0;
    w_cnt_nxt  = r_busy_cnt;
    if (bus.flush) begin
      w_busy_nxt = '0;
      w_cnt_nxt  = '0;
    end else begin
      if (w_wr_ok) begin
        w_busy_nxt[bus.wr_addr] = 1'b0;
        w_dec = r_busy[bus.wr_addr] &&
                !(w_rsv_ok && (bus.rsv_addr == bus.wr_addr));
      end
      if (w_rsv_ok) begin
        w_busy_nxt[bus.rsv_addr] = 1'b1;
        w_inc = !r_busy[bus.rsv_addr];
      end
      w_cnt_nxt = r_busy_cnt + CW'(w_inc) - CW'(w_dec);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      if (w_wr_ok) r_mem[bus.wr_addr] <= bus.wr_data;
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_ok;
    logic          w_byp;

    assign w_ra  = bus.rd_addr[g*AW +: AW];
    assign w_ok  = (int'(w_ra) < NREG) && !((ZERO_REG != 0) && (w_ra == '0));
    assign w_byp = w_wr_ok && (bus.wr_addr == w_ra);

    assign w_rd_data[g*XLEN +: XLEN] = !w_ok ? '0 :
                                       w_byp ? bus.wr_data : r_mem[w_ra];
    assign w_rd_busy[g] = w_ok && !w_byp && r_busy[w_ra];
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.rd_busy  = w_rd_busy;
  assign bus.busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default 8x32x2 instance driven from a vector
// table plus hand sequences, and a 32-bit, 20-entry, 3-port instance.
module tb_reg_file_sb;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  reg_file_sb_if #(.XLEN(8),  .NREG(32), .NRD(2)) if_a ();
  reg_file_sb_if #(.XLEN(32), .NREG(20), .NRD(3)) if_b ();

  reg_file_sb #(.XLEN(8), .NREG(32), .NRD(2), .ZERO_REG(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  reg_file_sb #(.XLEN(32), .NREG(20), .NRD(3), .ZERO_REG(1)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [4:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [4:0] ra;
    logic       fl;
    logic [4:0] a0;
    logic [4:0] a1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       b0;
    logic       b1;
    logic [5:0] cnt;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic we, input logic [4:0] wa, input logic [7:0] wd,
                         input logic re, input logic [4:0] ra, input logic fl,
                         input logic [4:0] a0, input logic [4:0] a1);
    if_a.wr_en    = we;
    if_a.wr_addr  = wa;
    if_a.wr_data  = wd;
    if_a.rsv_en   = re;
    if_a.rsv_addr = ra;
    if_a.flush    = fl;
    if_a.rd_addr  = {a1, a0};
  endtask

  task automatic drive_b(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra,
                         input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    if_b.wr_en    = we;
    if_b.wr_addr  = wa;
    if_b.wr_data  = wd;
    if_b.rsv_en   = re;
    if_b.rsv_addr = ra;
    if_b.flush    = 1'b0;
    if_b.rd_addr  = {a2, a1, a0};
  endtask

  task automatic chk_a(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                       input logic b0, input logic b1, input logic [5:0] cnt);
    chk({tag, " d0"},  32'(if_a.rd_data[7:0]),  32'(d0));
    chk({tag, " d1"},  32'(if_a.rd_data[15:8]), 32'(d1));
    chk({tag, " b0"},  32'(if_a.rd_busy[0]),    32'(b0));
    chk({tag, " b1"},  32'(if_a.rd_busy[1]),    32'(b1));
    chk({tag, " cnt"}, 32'(if_a.busy_cnt),      32'(cnt));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0, 0, 0);

    //          we wa     wd     re ra     fl a0     a1     d0     d1     b0 b1 cnt
    vecs[0]  = '{1, 5'd3, 8'hA5, 0, 5'd0,  0, 5'd1,  5'd2,  8'h00, 8'h00, 0, 0, 6'd0};
    vecs[1]  = '{0, 5'd0, 8'h00, 0, 5'd0,  0, 5'd3,  5'd3,  8'hA5, 8'hA5, 0, 0, 6'd0};
    vecs[2]  = '{1, 5'd3, 8'h3C, 0, 5'd0,  0, 5'd3,  5'd3,  8'h3C, 8'h3C, 0, 0, 6'd0};
    vecs[3]  = '{0, 5'd0, 8'h00, 0, 5'd0,  0, 5'd3,  5'd0,  8'h3C, 8'h00, 0, 0, 6'd0};
    vecs[4]  = '{1, 5'd0, 8'hFF, 1, 5'd0,  0, 5'd0,  5'd0,  8'h00, 8'h00, 0, 0, 6'd0};
    vecs[5]  = '{0, 5'd0, 8'h00, 0, 5'd0,  0, 5'd0,  5'd0,  8'h00, 8'h00, 0, 0, 6'd0};
    vecs[6]  = '{0, 5'd0, 8'h00, 1, 5'd5,  0, 5'd5,  5'd7,  8'h00, 8'h00, 0, 0, 6'd0};
    vecs[7]  = '{0, 5'd0, 8'h00, 1, 5'd7,  0, 5'd5,  5'd7,  8'h00, 8'h00, 1, 0, 6'd1};
    vecs[8]  = '{0, 5'd0, 8'h00, 1, 5'd5,  0, 5'd5,  5'd7,  8'h00, 8'h00, 1, 1, 6'd2};
    vecs[9]  = '{1, 5'd5, 8'h11, 0, 5'd0,  0, 5'd5,  5'd7,  8'h11, 8'h00, 0, 1, 6'd2};
    vecs[10] = '{0, 5'd0, 8'h00, 0, 5'd0,  0, 5'd5,  5'd7,  8'h11, 8'h00, 0, 1, 6'd1};
    vecs[11] = '{1, 5'd9, 8'h77, 1, 5'd9,  0, 5'd9,  5'd7,  8'h77, 8'h00, 0, 1, 6'd1};
    vecs[12] = '{0, 5'd0, 8'h00, 0, 5'd0,  0, 5'd9,  5'd7,  8'h77, 8'h00, 1, 1, 6'd2};
    vecs[13] = '{0, 5'd0, 8'h00, 1, 5'd4,  1, 5'd4,  5'd9,  8'h00, 8'h77, 0, 1, 6'd2};
    vecs[14] = '{0, 5'd0, 8'h00, 0, 5'd0,  0, 5'd4,  5'd9,  8'h00, 8'h77, 0, 0, 6'd0};
    vecs[15] = '{1, 5'd3, 8'h55, 1, 5'd10, 0, 5'd10, 5'd3,  8'h00, 8'h55, 0, 0, 6'd0};
    vecs[16] = '{1, 5'd10, 8'h66, 1, 5'd11, 0, 5'd10, 5'd11, 8'h66, 8'h00, 0, 0, 6'd1};
    vecs[17] = '{0, 5'd0, 8'h00, 0, 5'd0,  0, 5'd10, 5'd11, 8'h66, 8'h00, 0, 1, 6'd1};
    vecs[18] = '{1, 5'd12, 8'hAB, 0, 5'd0, 1, 5'd12, 5'd11, 8'hAB, 8'h00, 0, 1, 6'd1};
    vecs[19] = '{0, 5'd0, 8'h00, 0, 5'd0,  0, 5'd12, 5'd11, 8'hAB, 8'h00, 0, 0, 6'd0};

    // reset state while rst_n is still low
    #3;
    drive_a(0, 0, 0, 0, 0, 0, 5'd3, 5'd5);
    #1;
    chk_a("reset", 8'h00, 8'h00, 0, 0, 6'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive_a(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra,
              vecs[i].fl, vecs[i].a0, vecs[i].a1);
      #1;
      chk_a($sformatf("vec%0d", i), vecs[i].d0, vecs[i].d1, vecs[i].b0, vecs[i].b1, vecs[i].cnt);
    end

    // fill the scoreboard to its ceiling of NREG-1 and make sure it holds
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      drive_a(0, 0, 0, 1, 5'(r), 0, 5'd1, 5'd31);
    end
    @(negedge clk);
    drive_a(0, 0, 0, 0, 0, 0, 5'd31, 5'd1);
    #1;
    chk_a("full", 8'h00, 8'h00, 1, 1, 6'd31);
    @(negedge clk);
    drive_a(0, 0, 0, 1, 5'd31, 0, 5'd21, 5'd31);
    #1;
    chk_a("full_rersv", 8'h00, 8'h00, 1, 1, 6'd31);
    @(negedge clk);
    drive_a(1, 5'd21, 8'hCD, 0, 0, 0, 5'd21, 5'd20);
    #1;
    chk_a("full_wr", 8'hCD, 8'h00, 0, 1, 6'd31);
    @(negedge clk);
    drive_a(0, 0, 0, 0, 0, 0, 5'd21, 5'd20);
    #1;
    chk_a("after_wr", 8'hCD, 8'h00, 0, 1, 6'd30);

    // wide instance: independent ports and out-of-range address 25
    @(negedge clk);
    drive_b(1, 5'd1, 32'h1111_1111, 0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    drive_b(1, 5'd2, 32'h2222_2222, 0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    drive_b(1, 5'd19, 32'hDEAD_BEEF, 0, 0, 5'd1, 5'd2, 5'd19);
    #1;
    chk("b p0", if_b.rd_data[31:0],  32'h1111_1111);
    chk("b p1", if_b.rd_data[63:32], 32'h2222_2222);
    chk("b p2 byp", if_b.rd_data[95:64], 32'hDEAD_BEEF);
    @(negedge clk);
    drive_b(1, 5'd25, 32'h5555_AAAA, 1, 5'd25, 5'd2, 5'd19, 5'd25);
    #1;
    chk("b p0 r2",   if_b.rd_data[31:0],  32'h2222_2222);
    chk("b p1 r19",  if_b.rd_data[63:32], 32'hDEAD_BEEF);
    chk("b p2 oob",  if_b.rd_data[95:64], 32'h0);
    chk("b busy oob", 32'(if_b.rd_busy), 32'h0);
    @(negedge clk);
    drive_b(0, 0, 0, 1, 5'd19, 5'd1, 5'd19, 5'd25);
    #1;
    chk("b cnt oob", 32'(if_b.busy_cnt), 32'd0);
    chk("b p2 oob2", if_b.rd_data[95:64], 32'h0);
    @(negedge clk);
    drive_b(0, 0, 0, 0, 0, 5'd1, 5'd19, 5'd25);
    #1;
    chk("b cnt r19", 32'(if_b.busy_cnt), 32'd1);
    chk("b busy",    32'(if_b.rd_busy),  32'b010);
    chk("b p0 r1",   if_b.rd_data[31:0], 32'h1111_1111);

    // asynchronous reset mid-cycle with live data and busy bits
    @(negedge clk);
    drive_a(0, 0, 0, 0, 0, 0, 5'd21, 5'd20);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("async_rst", 8'h00, 8'h00, 0, 0, 6'd0);
    chk("b rst cnt",  32'(if_b.busy_cnt),   32'd0);
    chk("b rst busy", 32'(if_b.rd_busy),    32'h0);
    chk("b rst p1",   if_b.rd_data[63:32],  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_a(0, 0, 0, 1, 5'd6, 0, 5'd21, 5'd6);
    #1;
    chk_a("post_rst", 8'h00, 8'h00, 0, 0, 6'd0);
    @(negedge clk);
    drive_a(0, 0, 0, 0, 0, 0, 5'd21, 5'd6);
    #1;
    chk_a("post_rst_rsv", 8'h00, 8'h00, 0, 1, 6'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
